// File: rtl/laser_point_feeder_if.sv
// rtl/laser_point_feeder_if.sv - host point/result port and engine stimulus port of the point feeder
interface laser_point_feeder_if;
    logic       pt_we;
    logic [5:0] pt_addr;
    logic [3:0] pt_x;
    logic [3:0] pt_y;
    logic       start;
    logic       busy;
    logic       las_rst;
    logic [3:0] las_x;
    logic [3:0] las_y;
    logic       las_done;
    logic [3:0] las_c1x;
    logic [3:0] las_c1y;
    logic [3:0] las_c2x;
    logic [3:0] las_c2y;
    logic [3:0] res_c1x;
    logic [3:0] res_c1y;
    logic [3:0] res_c2x;
    logic [3:0] res_c2y;
    logic [5:0] res_score;
    logic       res_valid;
    logic       err_timeout;

    // slave is the feeder itself; master is the host plus engine environment
    modport slave (
        input  pt_we, pt_addr, pt_x, pt_y, start,
        input  las_done, las_c1x, las_c1y, las_c2x, las_c2y,
        output busy, las_rst, las_x, las_y,
        output res_c1x, res_c1y, res_c2x, res_c2y, res_score, res_valid, err_timeout
    );
    modport master (
        output pt_we, pt_addr, pt_x, pt_y, start,
        output las_done, las_c1x, las_c1y, las_c2x, las_c2y,
        input  busy, las_rst, las_x, las_y,
        input  res_c1x, res_c1y, res_c2x, res_c2y, res_score, res_valid, err_timeout
    );
endinterface

// File: rtl/laser_point_feeder.sv
// rtl/laser_point_feeder.sv - feeds a point set to the laser engine, captures centres, scores coverage
module laser_point_feeder #(
    parameter int NUM_PTS   = 40,
    parameter int RADIUS_SQ = 16,
    parameter int TIMEOUT   = 16383
) (
    input logic                 clk,
    input logic                 rst,
    laser_point_feeder_if.slave bus
);
    typedef enum logic [2:0] {IDLE, FEED, WAIT_DONE, SCORE, REPORT} state_t;

    localparam int         TW   = $clog2(TIMEOUT + 1);
    localparam logic [5:0] LAST = 6'(NUM_PTS - 1);
    localparam logic [5:0] NPTS = 6'(NUM_PTS);

    state_t        state, next_state;
    logic [5:0]    idx;
    logic [TW-1:0] tmo;
    logic [5:0]    acc;
    logic [3:0]    mem_x [NUM_PTS];
    logic [3:0]    mem_y [NUM_PTS];
    logic          wr_en;
    logic [5:0]    rd_idx;
    logic [3:0]    rd_x, rd_y;
    logic          tmo_hit, covered;
    logic          busy_d, las_rst_d;
    logic [3:0]    las_x_d, las_y_d;

    function automatic logic [8:0] dist_sq(input logic [3:0] ax, ay, bx, by);
        logic signed [4:0] dx, dy;
        logic [3:0]        adx, ady;
        logic [7:0]        sqx, sqy;
        dx  = $signed({1'b0, ax}) - $signed({1'b0, bx});
        dy  = $signed({1'b0, ay}) - $signed({1'b0, by});
        adx = dx[4] ? 4'(-dx) : dx[3:0];
        ady = dy[4] ? 4'(-dy) : dy[3:0];
        sqx = {4'b0, adx} * {4'b0, adx};
        sqy = {4'b0, ady} * {4'b0, ady};
        return {1'b0, sqx} + {1'b0, sqy};
    endfunction

    assign wr_en   = bus.pt_we && (state == IDLE) && (bus.pt_addr < NPTS);
    assign tmo_hit = (tmo == TW'(TIMEOUT - 1));
    assign rd_idx  = (state == FEED && idx != LAST) ? idx + 6'd1 : 6'd0;
    assign covered = (dist_sq(mem_x[idx], mem_y[idx], bus.res_c1x, bus.res_c1y) <= 9'(RADIUS_SQ)) ||
                     (dist_sq(mem_x[idx], mem_y[idx], bus.res_c2x, bus.res_c2y) <= 9'(RADIUS_SQ));

    // A write in the start cycle must reach the first fed point, hence the bypass
    always_comb begin
        rd_x = mem_x[rd_idx];
        rd_y = mem_y[rd_idx];
        if (wr_en && bus.pt_addr == rd_idx) begin
            rd_x = bus.pt_x;
            rd_y = bus.pt_y;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_x[bus.pt_addr] <= bus.pt_x;
            mem_y[bus.pt_addr] <= bus.pt_y;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (bus.start) next_state = FEED;
            FEED:      if (idx == LAST) next_state = WAIT_DONE;
            WAIT_DONE: begin
                if (bus.las_done)  next_state = SCORE;
                else if (tmo_hit)  next_state = IDLE;
            end
            SCORE:     if (idx == LAST) next_state = REPORT;
            REPORT:    next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    // Output values are decoded from the upcoming state so they register alongside it
    always_comb begin
        busy_d    = (next_state != IDLE);
        las_rst_d = (next_state == IDLE) || (next_state == SCORE) || (next_state == REPORT);
        las_x_d   = 4'd0;
        las_y_d   = 4'd0;
        if (next_state == FEED) begin
            las_x_d = rd_x;
            las_y_d = rd_y;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            idx             <= '0;
            tmo             <= '0;
            acc             <= '0;
            bus.busy        <= 1'b0;
            bus.las_rst     <= 1'b1;
            bus.las_x       <= '0;
            bus.las_y       <= '0;
            bus.res_c1x     <= '0;
            bus.res_c1y     <= '0;
            bus.res_c2x     <= '0;
            bus.res_c2y     <= '0;
            bus.res_score   <= '0;
            bus.res_valid   <= 1'b0;
            bus.err_timeout <= 1'b0;
        end else begin
            state         <= next_state;
            bus.busy      <= busy_d;
            bus.las_rst   <= las_rst_d;
            bus.las_x     <= las_x_d;
            bus.las_y     <= las_y_d;
            bus.res_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        idx             <= '0;
                        bus.err_timeout <= 1'b0;
                    end
                end
                FEED: begin
                    idx <= (idx == LAST) ? 6'd0 : idx + 6'd1;
                    tmo <= '0;
                end
                WAIT_DONE: begin
                    if (bus.las_done) begin
                        bus.res_c1x <= bus.las_c1x;
                        bus.res_c1y <= bus.las_c1y;
                        bus.res_c2x <= bus.las_c2x;
                        bus.res_c2y <= bus.las_c2y;
                        idx         <= '0;
                        acc         <= '0;
                    end else if (tmo_hit) begin
                        bus.err_timeout <= 1'b1;
                        bus.res_valid   <= 1'b1;
                        bus.res_score   <= '0;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                SCORE: begin
                    acc <= acc + 6'(covered);
                    idx <= (idx == LAST) ? 6'd0 : idx + 6'd1;
                    if (idx == LAST) begin
                        bus.res_score <= acc + 6'(covered);
                        bus.res_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_laser_point_feeder.sv
// tb/tb_laser_point_feeder.sv - scoreboard bench for laser_point_feeder with a stub engine
module tb_laser_point_feeder;
    localparam int NP  = 40;
    localparam int TMO = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    laser_point_feeder_if bus();
    laser_point_feeder #(.NUM_PTS(NP), .RADIUS_SQ(16), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typedef struct {
        int score; int c1x; int c1y; int c2x; int c2y; int err; int low;
    } res_t;

    res_t rq[$];
    int   fq[$];
    int   mx[NP];
    int   my[NP];
    int   lc1x = 0, lc1y = 0, lc2x = 0, lc2y = 0;
    int   n_chk = 0, n_fail = 0, n_valid = 0;
    int   cyc = 0, run_cyc = 0, last_low = 0, done_cyc = 0;
    int   prev_valid = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: feed stream and result strobes checked against the scoreboard queues
    initial begin
        res_t e;
        int   ef;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst || bus.las_rst) begin
                run_cyc = 0;
            end else begin
                run_cyc++;
                last_low = run_cyc;
                if (run_cyc <= NP) begin
                    if (fq.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL feed_unexpected: point at run cycle %0d, none expected", run_cyc);
                    end else begin
                        ef = fq.pop_front();
                        chk("feed_point", int'(bus.las_x) * 16 + int'(bus.las_y), ef);
                    end
                end else if (bus.las_done) begin
                    done_cyc = cyc;
                end
            end
            if (!rst && bus.res_valid) begin
                n_valid++;
                chk("valid_single_cycle", prev_valid, 0);
                if (rq.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_valid: res_valid with no result expected");
                end else begin
                    e = rq.pop_front();
                    chk("res_score",   int'(bus.res_score),   e.score);
                    chk("res_c1x",     int'(bus.res_c1x),     e.c1x);
                    chk("res_c1y",     int'(bus.res_c1y),     e.c1y);
                    chk("res_c2x",     int'(bus.res_c2x),     e.c2x);
                    chk("res_c2y",     int'(bus.res_c2y),     e.c2y);
                    chk("err_timeout", int'(bus.err_timeout), e.err);
                    chk("las_rst_low_cycles", last_low, e.low);
                    if (e.err == 0) chk("done_to_valid_latency", cyc - done_cyc, 41);
                end
            end
            prev_valid = int'(bus.res_valid);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_pt(input int a, input int x, input int y);
        bus.pt_we   = 1'b1;
        bus.pt_addr = 6'(a);
        bus.pt_x    = 4'(x);
        bus.pt_y    = 4'(y);
        tick();
        bus.pt_we = 1'b0;
        if (a < NP) begin
            mx[a] = x;
            my[a] = y;
        end
    endtask

    function automatic int model_score(input int c1x, c1y, c2x, c2y);
        int s = 0;
        for (int i = 0; i < NP; i++) begin
            int d1 = (mx[i] - c1x) * (mx[i] - c1x) + (my[i] - c1y) * (my[i] - c1y);
            int d2 = (mx[i] - c2x) * (mx[i] - c2x) + (my[i] - c2y) * (my[i] - c2y);
            if (d1 <= 16 || d2 <= 16) s++;
        end
        return s;
    endfunction

    // delay = WAIT_DONE cycles before DONE is raised; delay >= TMO means DONE never comes
    task automatic run(input int c1x, c1y, c2x, c2y, input int delay,
                       input bit noise, input bit mid, input bit simul);
        res_t e;
        int   v0;
        if (simul) begin
            mx[0]       = $urandom_range(15);
            my[0]       = $urandom_range(15);
            bus.pt_we   = 1'b1;
            bus.pt_addr = 6'd0;
            bus.pt_x    = 4'(mx[0]);
            bus.pt_y    = 4'(my[0]);
        end
        for (int i = 0; i < NP; i++) fq.push_back(mx[i] * 16 + my[i]);
        if (delay < TMO) begin
            e.score = model_score(c1x, c1y, c2x, c2y);
            e.c1x = c1x; e.c1y = c1y; e.c2x = c2x; e.c2y = c2y;
            e.err = 0;
            e.low = NP + delay + 1;
            lc1x = c1x; lc1y = c1y; lc2x = c2x; lc2y = c2y;
        end else begin
            e.score = 0;
            e.c1x = lc1x; e.c1y = lc1y; e.c2x = lc2x; e.c2y = lc2y;
            e.err = 1;
            e.low = NP + TMO;
        end
        rq.push_back(e);
        v0 = n_valid;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.pt_we = 1'b0;
        for (int c = 1; c <= NP; c++) begin
            if (c == 1) chk("busy_in_feed", int'(bus.busy), 1);
            if (noise && c == 5) begin
                bus.las_done = 1'b1;
                bus.las_c1x = 4'd15; bus.las_c1y = 4'd15; bus.las_c2x = 4'd15; bus.las_c2y = 4'd15;
            end
            if (mid && c == 10) begin
                bus.start   = 1'b1;
                bus.pt_we   = 1'b1;
                bus.pt_addr = 6'd35;
                bus.pt_x    = 4'(15 - mx[35]);
                bus.pt_y    = 4'(15 - my[35]);
            end
            tick();
            bus.las_done = 1'b0;
            bus.start    = 1'b0;
            bus.pt_we    = 1'b0;
        end
        if (delay < TMO) begin
            repeat (delay) tick();
            bus.las_done = 1'b1;
            bus.las_c1x = 4'(c1x); bus.las_c1y = 4'(c1y);
            bus.las_c2x = 4'(c2x); bus.las_c2y = 4'(c2y);
            tick();
            bus.las_done = 1'b0;
        end
        for (int t = 0; t < TMO + NP + 20 && n_valid == v0; t++) @(posedge clk);
        #1;
        chk("run_completed", n_valid - v0, 1);
        chk("busy_after_run", int'(bus.busy), 0);
        chk("las_rst_after_run", int'(bus.las_rst), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int v0;
        bus.pt_we = 1'b0; bus.pt_addr = '0; bus.pt_x = '0; bus.pt_y = '0; bus.start = 1'b0;
        bus.las_done = 1'b0;
        bus.las_c1x = '0; bus.las_c1y = '0; bus.las_c2x = '0; bus.las_c2y = '0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_las_rst",     int'(bus.las_rst), 1);
        chk("rst_busy",        int'(bus.busy), 0);
        chk("rst_res_valid",   int'(bus.res_valid), 0);
        chk("rst_las_x",       int'(bus.las_x), 0);
        chk("rst_las_y",       int'(bus.las_y), 0);
        chk("rst_err_timeout", int'(bus.err_timeout), 0);
        chk("rst_res_score",   int'(bus.res_score), 0);
        chk("rst_res_c1x",     int'(bus.res_c1x), 0);

        // all points on C1
        for (int i = 0; i < NP; i++) wr_pt(i, 8, 8);
        run(8, 8, 0, 0, 3, 1'b0, 1'b0, 1'b0);

        // ordered stream, DONE during FEED and start/pt_we while busy must be ignored
        for (int i = 0; i < NP; i++) wr_pt(i, i % 16, i / 16);
        run($urandom_range(15), $urandom_range(15), $urandom_range(15), $urandom_range(15),
            0, 1'b1, 1'b1, 1'b0);

        // radius boundary points, plus out-of-range writes that must not land anywhere
        for (int i = 0; i < NP; i++) wr_pt(i, 8, 8);
        wr_pt(0, 4, 0); wr_pt(1, 2, 3); wr_pt(2, 3, 2); wr_pt(3, 3, 3); wr_pt(4, 1, 4);
        wr_pt(40, 0, 0); wr_pt(63, 1, 1);
        run(0, 0, 15, 15, 5, 1'b0, 1'b0, 1'b0);

        // timeout, then DONE on the last permitted cycle
        run(0, 0, 0, 0, TMO, 1'b0, 1'b0, 1'b0);
        run($urandom_range(15), $urandom_range(15), $urandom_range(15), $urandom_range(15),
            TMO - 1, 1'b0, 1'b0, 1'b0);

        // reset in FEED cycle 20 aborts silently
        for (int i = 0; i < NP; i++) fq.push_back(mx[i] * 16 + my[i]);
        v0 = n_valid;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (19) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_las_rst",   int'(bus.las_rst), 1);
        chk("abort_busy",      int'(bus.busy), 0);
        chk("abort_res_valid", int'(bus.res_valid), 0);
        chk("abort_las_x",     int'(bus.las_x), 0);
        repeat (60) tick();
        chk("abort_no_valid", n_valid - v0, 0);
        fq.delete();
        lc1x = 0; lc1y = 0; lc2x = 0; lc2y = 0;
        run(0, 0, 0, 0, TMO, 1'b0, 1'b0, 1'b0);

        // random back-to-back runs, first with a write in the start cycle
        for (int i = 0; i < NP; i++) wr_pt(i, $urandom_range(15), $urandom_range(15));
        for (int r = 0; r < 3; r++)
            run($urandom_range(15), $urandom_range(15), $urandom_range(15), $urandom_range(15),
                $urandom_range(20), 1'b0, 1'b0, r == 0);

        chk("result_queue_drained", rq.size(), 0);
        chk("feed_queue_drained", fq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
